lsu_ctrl: RTL and testbench

//  Load/store sequencer between the core datapath and the single data-memory port.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_extract.sv | 26 ++
 rtl/lsu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: width/sign selects, FSM states
// and the access-size helpers used for lane masking and split detection.
package lsu_pkg;

    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_W  = 3'b010;
    localparam logic [2:0] SEL_BU = 3'b011;
    localparam logic [2:0] SEL_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Access size in bytes; unlisted encodings behave as a word.
    function automatic logic [2:0] sel_size(input logic [2:0] sel);
        case (sel)
            SEL_B, SEL_BU: sel_size = 3'd1;
            SEL_H, SEL_HU: sel_size = 3'd2;
            default:       sel_size = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] sel);
        case (sel)
            SEL_B, SEL_BU: size_mask = 4'b0001;
            SEL_H, SEL_HU: size_mask = 4'b0011;
            default:       size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Combinational load-data extraction: shifts the merged beats down by the byte
// offset, then selects byte/half/word with sign or zero extension.
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [63:0] beats,
    input  logic [1:0]  offset,
    input  logic [2:0]  sel,
    output logic [31:0] ld_data
);

    logic [63:0] shifted_s;

    // Byte-align the addressed datum, then extend it to a full register.
    always_comb begin
        shifted_s = beats >> {offset, 3'b000};
        case (sel)
            SEL_B:   ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            SEL_H:   ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            SEL_BU:  ld_data = {24'h000000, shifted_s[7:0]};
            SEL_HU:  ld_data = {16'h0000, shifted_s[15:0]};
            default: ld_data = shifted_s[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the single data-memory port: one or two word beats per
// request, lane-shifted store data and byte enables, extended load writeback.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        start_rdy,
    input  logic        is_store,
    input  logic [2:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        misalign
);

    state_t      state_r, state_nx;
    logic        is_store_r;
    logic [2:0]  sel_r;
    logic [31:0] addr_r, wdata_r, lo_r;

    logic        cur_store_s;
    logic [2:0]  cur_sel_s;
    logic [31:0] cur_addr_s, cur_wdata_s;
    logic        split_s;
    logic [63:0] w64_s;
    logic [7:0]  be8_s;
    logic [29:0] word_s;
    logic        accept_s, mis_s, ld_upd_s;
    logic        req_nx_s;
    logic [31:0] addr_nx_s, wd_nx_s;
    logic [3:0]  be_nx_s;
    logic [63:0] beats_s;
    logic [31:0] ext_s;

    // In IDLE the request comes straight from the ports so beat 0 can launch on accept.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_store_s = is_store;
            cur_sel_s   = sel;
            cur_addr_s  = addr;
            cur_wdata_s = wdata;
        end else begin
            cur_store_s = is_store_r;
            cur_sel_s   = sel_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
        word_s  = cur_addr_s[31:2];
        split_s = ({1'b0, sel_size(cur_sel_s)} + {2'b00, cur_addr_s[1:0]}) > 4'd4;
        w64_s   = {32'h0000_0000, cur_wdata_s} << {cur_addr_s[1:0], 3'b000};
        be8_s   = {4'b0000, size_mask(cur_sel_s)} << cur_addr_s[1:0];
    end

    // Next-state logic and the one-shot control strobes.
    always_comb begin
        state_nx = state_r;
        accept_s = 1'b0;
        mis_s    = 1'b0;
        ld_upd_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (split_s && !MISALIGN_EN) begin
                        mis_s = 1'b1;
                    end else begin
                        accept_s = 1'b1;
                        state_nx = ST_BEAT0;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (split_s) begin
                        state_nx = ST_BEAT1;
                    end else begin
                        state_nx = ST_DONE;
                        ld_upd_s = !is_store_r;
                    end
                end else begin
                    state_nx = ST_BEAT0;
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    state_nx = ST_DONE;
                    ld_upd_s = !is_store_r;
                end else begin
                    state_nx = ST_BEAT1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Beat outputs are computed for the state being entered, so they are registered
    // and stay frozen while a beat waits on mem_ready.
    always_comb begin
        req_nx_s  = 1'b0;
        addr_nx_s = mem_addr;
        be_nx_s   = mem_be;
        wd_nx_s   = mem_wdata;
        case (state_nx)
            ST_BEAT0: begin
                req_nx_s  = 1'b1;
                addr_nx_s = {word_s, 2'b00};
                be_nx_s   = cur_store_s ? be8_s[3:0] : 4'b1111;
                wd_nx_s   = cur_store_s ? w64_s[31:0] : 32'h0000_0000;
            end
            ST_BEAT1: begin
                req_nx_s  = 1'b1;
                addr_nx_s = {word_s + 30'd1, 2'b00};
                be_nx_s   = cur_store_s ? be8_s[7:4] : 4'b1111;
                wd_nx_s   = cur_store_s ? w64_s[63:32] : 32'h0000_0000;
            end
            default: begin
                req_nx_s = 1'b0;
            end
        endcase
    end

    // The final beat's read data bypasses lo_r so ld_data is ready together with done.
    always_comb begin
        if (state_r == ST_BEAT1) begin
            beats_s = {mem_rdata, lo_r};
        end else begin
            beats_s = {32'h0000_0000, mem_rdata};
        end
    end

    lsu_extract u_extract (
        .beats   (beats_s),
        .offset  (addr_r[1:0]),
        .sel     (sel_r),
        .ld_data (ext_s)
    );

    // State, request capture, low-beat capture and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            is_store_r <= 1'b0;
            sel_r      <= 3'b000;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            lo_r       <= 32'h0000_0000;
            start_rdy  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0000_0000;
            done       <= 1'b0;
            ld_data    <= 32'h0000_0000;
            misalign   <= 1'b0;
        end else begin
            state_r <= state_nx;
            if (accept_s) begin
                is_store_r <= is_store;
                sel_r      <= sel;
                addr_r     <= addr;
                wdata_r    <= wdata;
            end
            if ((state_r == ST_BEAT0) && mem_ready && !is_store_r) begin
                lo_r <= mem_rdata;
            end
            if (ld_upd_s) begin
                ld_data <= ext_s;
            end
            start_rdy <= (state_nx == ST_IDLE);
            mem_req   <= req_nx_s;
            mem_we    <= req_nx_s && cur_store_s;
            mem_addr  <= addr_nx_s;
            mem_be    <= be_nx_s;
            mem_wdata <= wd_nx_s;
            done      <= (state_nx == ST_DONE);
            misalign  <= mis_s;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table with a done-driven scoreboard,
// plus hand sequences for wait states, mid-operation reset and misalign reporting.
module tb_lsu_ctrl;

    logic        clk, rst_n, start, start2, is_store, mem_ready;
    logic [2:0]  sel;
    logic [31:0] addr, wdata, mem_rdata;
    logic        start_rdy, mem_req, mem_we, done, misalign;
    logic [31:0] mem_addr, mem_wdata, ld_data;
    logic [3:0]  mem_be;
    logic        start_rdy2, mem_req2, mem_we2, done2, misalign2;
    logic [31:0] mem_addr2, mem_wdata2, ld_data2;
    logic [3:0]  mem_be2;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_rdy(start_rdy),
        .is_store(is_store), .sel(sel), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .done(done), .ld_data(ld_data), .misalign(misalign)
    );

    lsu_ctrl #(.MISALIGN_EN(1'b0)) dut_nomis (
        .clk(clk), .rst_n(rst_n), .start(start2), .start_rdy(start_rdy2),
        .is_store(is_store), .sel(sel), .addr(addr), .wdata(wdata),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_be(mem_be2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .done(done2), .ld_data(ld_data2), .misalign(misalign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-word memory model around the addressed word.
    logic [31:0] lo_a, lo_v, hi_a, hi_v;
    assign mem_rdata = (mem_addr == lo_a) ? lo_v :
                       (mem_addr == hi_a) ? hi_v : 32'hBAD0_BAD0;

    typedef struct {
        logic        is_store;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] exp_ld;
        int          nbeats;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } beat_t;

    vec_t        vecs [15];
    exp_t        sb_q [$];
    beat_t       obs_q [$];
    logic [31:0] model_ld;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ready) begin
            obs_q.push_back('{mem_addr, mem_be, mem_wdata, mem_we});
        end
    end

    always @(negedge clk) begin : done_mon
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = sb_q.pop_front();
                chk("ld_data", ld_data, e.ld);
            end
        end
        if (rst_n && done2) begin
            checks++;
            errors++;
            $display("FAIL nomis_done: got done=1 expected 0");
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        lo_a = {v.addr[31:2], 2'b00};
        lo_v = v.lo;
        hi_a = lo_a + 32'd4;
        hi_v = v.hi;
        obs_q.delete();
        @(negedge clk);
        is_store = v.is_store; sel = v.sel; addr = v.addr; wdata = v.wdata; start = 1'b1;
        if (!v.is_store) model_ld = v.exp_ld;
        sb_q.push_back('{model_ld});
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d start_rdy_busy", idx), {31'd0, start_rdy}, 32'd0);
        chk($sformatf("v%0d misalign", idx), {31'd0, misalign}, 32'd0);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(1 + v.nbeats));
        chk($sformatf("v%0d beats", idx), 32'(obs_q.size()), 32'(v.nbeats));
        if (obs_q.size() >= 1) begin
            chk($sformatf("v%0d addr0", idx), obs_q[0].a, lo_a);
            chk($sformatf("v%0d be0", idx), {28'd0, obs_q[0].be}, {28'd0, v.be0});
            chk($sformatf("v%0d we0", idx), {31'd0, obs_q[0].we}, {31'd0, v.is_store});
            if (v.is_store) chk($sformatf("v%0d wd0", idx), obs_q[0].wd, v.wd0);
        end
        if (obs_q.size() >= 2) begin
            chk($sformatf("v%0d addr1", idx), obs_q[1].a, hi_a);
            chk($sformatf("v%0d be1", idx), {28'd0, obs_q[1].be}, {28'd0, v.be1});
            if (v.is_store) chk($sformatf("v%0d wd1", idx), obs_q[1].wd, v.wd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        //        st    sel     addr          wdata         lo            hi            exp_ld       nb be0    wd0           be1    wd1
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 32'h0, 32'hFFFF_FF80, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[2]  = '{1'b0, 3'b011, 32'h0000_0102, 32'h0, 32'h0080_0000, 32'h0, 32'h0000_0080, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'h8011_2233, 32'hAABB_CCDD, 32'hFFFF_DD80, 2, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0103, 32'h0, 32'h8011_2233, 32'hAABB_CCDD, 32'h0000_DD80, 2, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8011_2233, 32'h0, 32'hFFFF_8011, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h4433_2211, 32'h8877_6655, 32'h5544_3322, 2, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h0000_F00D, 32'h0, 32'h0000_F00D, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h7F00_0000, 32'h0, 32'h0000_007F, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 3'b111, 32'h0000_010C, 32'h0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h1234_ABCD, 32'h0000_5678, 32'h5678_1234, 2, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[11] = '{1'b1, 3'b010, 32'h0000_0106, 32'h1122_3344, 32'h0, 32'h0, 32'h0, 2, 4'b1100, 32'h3344_0000, 4'b0011, 32'h0000_1122};
        vecs[12] = '{1'b1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 32'h0, 32'h0, 32'h0, 1, 4'b0010, 32'h3456_AB00, 4'h0, 32'h0};
        vecs[13] = '{1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0, 2, 4'b1000, 32'hEF00_0000, 4'b0001, 32'h0000_00BE};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h0000_00FF, 32'h0, 32'hFFFF_FFFF, 1, 4'hF, 32'h0, 4'hF, 32'h0};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; is_store = 1'b0; sel = 3'b010;
        addr = 32'h0; wdata = 32'h0; mem_ready = 1'b1; model_ld = 32'h0;
        lo_a = 32'h0; lo_v = 32'h0; hi_a = 32'h4; hi_v = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst misalign", {31'd0, misalign}, 32'd0);
        chk("rst start_rdy", {31'd0, start_rdy}, 32'd1);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst ld_data", ld_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Wait states on an aligned load, with a stray start mid-operation.
        lo_a = 32'h200; lo_v = 32'h0BAD_F00D; hi_a = 32'h204; hi_v = 32'h0;
        obs_q.delete();
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; sel = 3'b010; addr = 32'h200;
        model_ld = 32'h0BAD_F00D;
        sb_q.push_back('{model_ld});
        @(negedge clk);
        start = 1'b0;
        chk("wait c1 mem_req", {31'd0, mem_req}, 32'd1);
        chk("wait c1 mem_addr", mem_addr, 32'h200);
        chk("wait c1 start_rdy", {31'd0, start_rdy}, 32'd0);
        @(negedge clk);
        chk("wait c2 mem_addr", mem_addr, 32'h200);
        start = 1'b1; addr = 32'h300; sel = 3'b000;
        @(negedge clk);
        start = 1'b0;
        chk("wait c3 mem_addr", mem_addr, 32'h200);
        chk("wait c3 mem_be", {28'd0, mem_be}, 32'hF);
        chk("wait c3 mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        cyc = 4;
        chk("wait c4 mem_req", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait latency", 32'(cyc), 32'd5);
        @(negedge clk);
        chk("wait idle mem_req", {31'd0, mem_req}, 32'd0);
        chk("wait idle start_rdy", {31'd0, start_rdy}, 32'd1);
        @(negedge clk);
        chk("wait stray ignored", {31'd0, mem_req}, 32'd0);
        chk("wait beats", 32'(obs_q.size()), 32'd1);

        // Asynchronous reset while the second beat waits.
        lo_a = 32'h100; lo_v = 32'h8011_2233; hi_a = 32'h104; hi_v = 32'hAABB_CCDD;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; sel = 3'b001; addr = 32'h103;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid beat1 addr", mem_addr, 32'h104);
        chk("rstmid beat1 req", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid start_rdy", {31'd0, start_rdy}, 32'd1);
        chk("rstmid ld_data", ld_data, 32'h0);
        model_ld = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid idle mem_req", {31'd0, mem_req}, 32'd0);
        end

        // Misaligned word on the instance without splitting.
        @(negedge clk);
        start2 = 1'b1; is_store = 1'b0; sel = 3'b010; addr = 32'h101;
        @(negedge clk);
        start2 = 1'b0;
        chk("nomis misalign", {31'd0, misalign2}, 32'd1);
        chk("nomis mem_req", {31'd0, mem_req2}, 32'd0);
        chk("nomis start_rdy", {31'd0, start_rdy2}, 32'd1);
        @(negedge clk);
        chk("nomis pulse", {31'd0, misalign2}, 32'd0);
        chk("nomis mem_req2", {31'd0, mem_req2}, 32'd0);
        chk("sb drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
